// File: rtl/neuron_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_argmax
//  Purpose  : Takes a stream of neuron sums, NUM_NEURONS per frame, from the
//             MAC/accumulate stage. Every sum is requantized to an 8-bit
//             activation. At the end of each frame the block reports the
//             index and value of the largest sum.
//  Options  : NEURON_ARGMAX_RELU_EN -- when defined, negative sums are
//             clamped to 0 before the compare and the requantize, and
//             act_out is unsigned (0..255). When undefined, the compare
//             is signed and act_out is signed (-128..127).
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_argmax #(
    parameter int NUM_NEURONS = 10,
    parameter int P_WIDTH     = 22,
    parameter int SHIFT       = 8
) (
    input  logic                      clk,
    input  logic                      rst,        // asynchronous, active-low
    input  logic signed [P_WIDTH-1:0] p_in,
    input  logic                      p_valid,
    input  logic                      clear,
    output logic [7:0]                act_out,
    output logic                      act_valid,
    output logic [3:0]                digit,
    output logic signed [P_WIDTH-1:0] max_val,
    output logic                      done,
    output logic                      busy
);

    // Index of the final sum in a frame. The 4-bit index limits a frame to
    // 16 neurons, which matches the width of digit.
    localparam logic [3:0] c_LAST = 4'(NUM_NEURONS - 1);

`ifdef NEURON_ARGMAX_RELU_EN
    localparam logic signed [P_WIDTH-1:0] c_SAT_HI = P_WIDTH'(255);
`else
    localparam logic signed [P_WIDTH-1:0] c_SAT_HI = P_WIDTH'(127);
    localparam logic signed [P_WIDTH-1:0] c_SAT_LO = P_WIDTH'(-128);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [3:0]                r_idx;      // position of the next sum in the frame
    logic [3:0]                r_run_idx;  // index of the running maximum
    logic signed [P_WIDTH-1:0] r_run_max;  // running maximum

    logic                      w_accept;
    logic                      w_first;
    logic                      w_last;
    logic                      w_take;
    logic signed [P_WIDTH-1:0] w_cmp;
    logic signed [P_WIDTH-1:0] w_shifted;
    logic signed [P_WIDTH-1:0] w_new_max;
    logic [3:0]                w_new_idx;
    logic [7:0]                w_act;

    // Compare value, candidate running max/index, and saturated activation
    always_comb begin
        w_accept = p_valid & ~clear;    // clear beats a simultaneous sum
        w_first  = (r_idx == 4'd0);
        w_last   = (r_idx == c_LAST);
`ifdef NEURON_ARGMAX_RELU_EN
        w_cmp    = p_in[P_WIDTH-1] ? '0 : p_in;
`else
        w_cmp    = p_in;
`endif
        // Strictly greater only, so a tie keeps the earlier (lower) index
        w_take    = w_first || (w_cmp > r_run_max);
        w_new_max = w_take ? w_cmp : r_run_max;
        w_new_idx = w_take ? r_idx : r_run_idx;

        w_shifted = w_cmp >>> SHIFT;
`ifdef NEURON_ARGMAX_RELU_EN
        // With the clamp in front, w_shifted can never be negative
        if (w_shifted > c_SAT_HI) w_act = 8'hFF;
        else                      w_act = w_shifted[7:0];
`else
        if (w_shifted > c_SAT_HI)      w_act = 8'h7F;
        else if (w_shifted < c_SAT_LO) w_act = 8'h80;
        else                           w_act = w_shifted[7:0];
`endif
    end

    // Frame FSM, index counter, running argmax and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_run_idx <= 4'd0;
            r_run_max <= '0;
            act_out   <= 8'd0;
            act_valid <= 1'b0;
            digit     <= 4'd0;
            max_val   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            // Abort the partial frame. The last completed result is kept.
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_run_idx <= 4'd0;
            r_run_max <= '0;
            act_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else if (w_accept) begin
            act_out   <= w_act;
            act_valid <= 1'b1;
            r_run_max <= w_new_max;
            r_run_idx <= w_new_idx;
            if (w_last) begin
                r_state <= S_DONE;
                r_idx   <= 4'd0;
                digit   <= w_new_idx;
                max_val <= w_new_max;
                done    <= 1'b1;
                busy    <= 1'b0;
            end else begin
                r_state <= S_ACCUM;
                r_idx   <= r_idx + 4'd1;
                done    <= 1'b0;
                busy    <= 1'b1;
            end
        end else begin
            act_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= (r_state == S_ACCUM);
            if (r_state == S_DONE) r_state <= S_IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_argmax
//  Purpose  : Directed, self-checking bench for neuron_argmax using the
//             default parameters (10 neurons, 22-bit sums, shift of 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_argmax;

    logic               clk;
    logic               rst;
    logic signed [21:0] p_in;
    logic               p_valid;
    logic               clear;
    logic [7:0]         act_out;
    logic               act_valid;
    logic [3:0]         digit;
    logic signed [21:0] max_val;
    logic               done;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int v[10];

    neuron_argmax #(.NUM_NEURONS(10), .P_WIDTH(22), .SHIFT(8)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .clear(clear),
        .act_out(act_out), .act_valid(act_valid), .digit(digit),
        .max_val(max_val), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled away from the rising edge
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference requantization: floor(x / 256), then saturate
    function automatic logic [7:0] exp_act(input int x);
        int s;
`ifdef NEURON_ARGMAX_RELU_EN
        if (x < 0) x = 0;
        s = x >>> 8;
        if (s > 255) s = 255;
`else
        s = x >>> 8;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    // Stream v[0..9] on consecutive cycles and check every activation, busy
    // and done, then the frame result. p_valid is left high so that a
    // following frame can run back-to-back. The caller drops it otherwise.
    task automatic frame(input string tag, input int exp_digit, input int exp_max);
        logic [21:0] em;
        em = 22'(exp_max);
        for (int i = 0; i < 10; i++) begin
            p_in    = 22'(v[i]);
            p_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_act_valid"}, {31'b0, act_valid}, 32'd1);
            chk({tag, "_act_out"}, {24'b0, act_out}, {24'b0, exp_act(v[i])});
            chk({tag, "_busy"}, {31'b0, busy}, (i < 9) ? 32'd1 : 32'd0);
            chk({tag, "_done"}, {31'b0, done}, (i < 9) ? 32'd0 : 32'd1);
        end
        chk({tag, "_digit"}, {28'b0, digit}, 32'(exp_digit));
        chk({tag, "_max_val"}, {10'b0, max_val}, {10'b0, em});
    endtask

    task automatic idle_cycle();
        p_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; p_in = '0; p_valid = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_act_out", {24'b0, act_out}, 32'd0);
        chk("rst_act_valid", {31'b0, act_valid}, 32'd0);
        chk("rst_digit", {28'b0, digit}, 32'd0);
        chk("rst_max_val", {10'b0, max_val}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Saturation boundaries; the maximum 70000 sits at index 0
        v = '{70000, -70000, 32767, 32768, -32768, -32769, 255, 256, -256, -257};
        frame("sat", 0, 70000);

        // All negative, starting back-to-back from the DONE cycle
        v = '{-100, -50, -30, -20, -1, -8, -5, -3, -2, -64};
`ifdef NEURON_ARGMAX_RELU_EN
        frame("neg", 0, 0);
`else
        frame("neg", 4, -1);
`endif

        // Tie at 50: index 1 must win over index 3
        v = '{10, 50, 30, 50, -5, 0, 7, 49, 1, 2};
        frame("tie", 1, 50);
        idle_cycle();
        chk("tie_done_drop", {31'b0, done}, 32'd0);
        chk("tie_valid_drop", {31'b0, act_valid}, 32'd0);
        chk("tie_busy_idle", {31'b0, busy}, 32'd0);

        // Five large sums, then clear arrives together with a sixth sum
        for (int i = 0; i < 5; i++) begin
            p_in = 22'((i + 1) * 1000); p_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("clr_busy_before", {31'b0, busy}, 32'd1);
        p_in = 22'(9000); clear = 1'b1;
        @(posedge clk); #1;
        chk("clr_no_act_valid", {31'b0, act_valid}, 32'd0);
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_digit_kept", {28'b0, digit}, 32'd1);
        chk("clr_max_kept", {10'b0, max_val}, 32'd50);
        chk("clr_no_done", {31'b0, done}, 32'd0);
        clear = 1'b0;
        v = '{5, 4, 3, 2, 1, 0, -1, -2, 100, 99};
        frame("post_clr", 8, 100);
        idle_cycle();

        // Reset in the middle of a frame after seven sums
        for (int i = 0; i < 7; i++) begin
            p_in = 22'(1000 + i); p_valid = 1'b1;
            @(posedge clk); #1;
        end
        p_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_digit", {28'b0, digit}, 32'd0);
        chk("mid_rst_act_valid", {31'b0, act_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        done_cnt = 0;
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 500};
        frame("after_rst", 9, 500);
        idle_cycle();
        repeat (3) @(posedge clk);
        #1;
        chk("after_rst_done_once", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
